// File: rtl/pcfx_bk_sched.sv
// pcfx_bk_sched: backup-RAM load/save sequencer between HPS SD volumes and SDRAM.
// One sector at a time is staged through a 256x16 buffer; vol0 (SRAM) then vol1 (BMP).
module pcfx_bk_sched #(
   parameter logic [24:0] SRAM_BASE_A = 25'h0,
   parameter logic [24:0] BMP_BASE_A  = 25'h0,
   parameter int          MAX_SECT0   = 256,
   parameter int          MAX_SECT1   = 256
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic [1:0]  img_mounted,
   input  logic        img_readonly,
   input  logic [63:0] img_size,
   input  logic        bk_load,
   input  logic        bk_save,
   output logic        bk_ena,
   output logic        bk_loading,
   output logic        bk_saving,
   output logic [31:0] sd_lba,
   output logic [1:0]  sd_rd,
   output logic [1:0]  sd_wr,
   input  logic [1:0]  sd_ack,
   input  logic [7:0]  sd_buff_addr,
   input  logic [15:0] sd_buff_dout,
   input  logic        sd_buff_wr,
   output logic [15:0] sd_buff_din,
   output logic        mem_req,
   output logic        mem_we,
   output logic [24:0] mem_addr,
   output logic [15:0] mem_din,
   input  logic [15:0] mem_dout,
   input  logic        mem_ack
);
   typedef enum logic [2:0] {IDLE, L_REQ, L_XFER, L_MEM, S_MEM, S_REQ, S_XFER, NEXT} state_t;
   state_t state, state_n;
   logic [1:0][31:0] nsect, snap, cnt;
   logic [1:0]       ro, snap_ro, rov, elig;
   logic             vol, vol_n, save, save_n, prev_load, prev_save, ld_edge, sv_edge, mode;
   logic [31:0]      lba, lba_n;
   logic [7:0]       widx, widx_n;
   logic [15:0]      sect_buf [256];

   function automatic logic [31:0] clamp(input logic [63:0] s, input int m);
      logic [63:0] q;
      q = s >> 9;
      return (q > 64'(m)) ? 32'(m) : q[31:0];
   endfunction

   // In IDLE the live mount state decides eligibility; during an op the start snapshot does.
   assign cnt     = (state == IDLE) ? nsect : snap;
   assign rov     = (state == IDLE) ? ro : snap_ro;
   assign ld_edge = bk_load & ~prev_load;
   assign sv_edge = bk_save & ~prev_save;
   assign mode    = (state == IDLE) ? (!ld_edge && sv_edge) : save;
   assign elig[0] = (cnt[0] != 0) && !(mode && rov[0]);
   assign elig[1] = (cnt[1] != 0) && !(mode && rov[1]);

   assign bk_loading = (state != IDLE) && !save;
   assign bk_saving  = (state != IDLE) && save;
   assign sd_lba     = lba;
   assign mem_addr   = mem_req ? (vol ? BMP_BASE_A : SRAM_BASE_A) + {lba[15:0], 9'b0} + {16'b0, widx, 1'b0} : '0;
   assign mem_din    = (mem_req && mem_we) ? sect_buf[widx] : '0;

   always_comb begin
      state_n = state;
      vol_n   = vol;
      lba_n   = lba;
      widx_n  = widx;
      save_n  = save;
      sd_rd   = '0;
      sd_wr   = '0;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      case (state)
         IDLE:
            if ((ld_edge || sv_edge) && elig != 2'b00) begin
               save_n  = mode;
               vol_n   = !elig[0];
               lba_n   = '0;
               widx_n  = '0;
               state_n = mode ? S_MEM : L_REQ;
            end
         L_REQ: begin
            sd_rd[vol] = 1'b1;
            if (sd_ack[vol]) state_n = L_XFER;
         end
         L_XFER: if (!sd_ack[vol]) state_n = L_MEM;
         L_MEM: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (mem_ack) begin
               widx_n  = widx + 8'd1;
               state_n = (widx == 8'hFF) ? NEXT : L_MEM;
            end
         end
         S_MEM: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               widx_n  = widx + 8'd1;
               state_n = (widx == 8'hFF) ? S_REQ : S_MEM;
            end
         end
         S_REQ: begin
            sd_wr[vol] = 1'b1;
            if (sd_ack[vol]) state_n = S_XFER;
         end
         S_XFER: if (!sd_ack[vol]) state_n = NEXT;
         NEXT:
            if (lba + 32'd1 < cnt[vol]) begin
               lba_n   = lba + 32'd1;
               state_n = save ? S_MEM : L_REQ;
            end else if (!vol && elig[1]) begin
               vol_n   = 1'b1;
               lba_n   = '0;
               state_n = save ? S_MEM : L_REQ;
            end else begin
               lba_n   = '0;
               state_n = IDLE;
            end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         vol         <= 1'b0;
         lba         <= '0;
         widx        <= '0;
         save        <= 1'b0;
         nsect       <= '0;
         snap        <= '0;
         ro          <= '0;
         snap_ro     <= '0;
         bk_ena      <= 1'b0;
         prev_load   <= 1'b0;
         prev_save   <= 1'b0;
         sd_buff_din <= '0;
      end else begin
         state       <= state_n;
         vol         <= vol_n;
         lba         <= lba_n;
         widx        <= widx_n;
         save        <= save_n;
         prev_load   <= bk_load;
         prev_save   <= bk_save;
         sd_buff_din <= sect_buf[sd_buff_addr];
         if (state == IDLE) begin
            snap    <= nsect;
            snap_ro <= ro;
         end
         for (int v = 0; v < 2; v++)
            if (img_mounted[v]) begin
               nsect[v] <= clamp(img_size, (v == 0) ? MAX_SECT0 : MAX_SECT1);
               ro[v]    <= img_readonly;
            end
         if (img_mounted[0]) bk_ena <= clamp(img_size, MAX_SECT0) != 0;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (state == L_XFER && sd_buff_wr) sect_buf[sd_buff_addr] <= sd_buff_dout;
      else if (state == S_MEM && mem_ack) sect_buf[widx] <= mem_dout;
   end
endmodule

// File: tb/tb_pcfx_bk_sched.sv
// tb_pcfx_bk_sched: randomized SD host and SDRAM models against a sector-level reference model.
module tb_pcfx_bk_sched;
   localparam logic [24:0] SB = 25'h040000;
   localparam logic [24:0] BB = 25'h100000;
   localparam int MX0 = 256;
   localparam int MX1 = 4;

   logic        clk = 1'b0, reset = 1'b1;
   logic [1:0]  img_mounted = '0;
   logic        img_readonly = 1'b0;
   logic [63:0] img_size = '0;
   logic        bk_load = 1'b0, bk_save = 1'b0;
   logic        bk_ena, bk_loading, bk_saving;
   logic [31:0] sd_lba;
   logic [1:0]  sd_rd, sd_wr;
   logic [1:0]  sd_ack;
   logic [7:0]  sd_buff_addr;
   logic [15:0] sd_buff_dout;
   logic        sd_buff_wr;
   logic [15:0] sd_buff_din;
   logic        mem_req, mem_we, mem_ack;
   logic [24:0] mem_addr;
   logic [15:0] mem_din, mem_dout;

   pcfx_bk_sched #(.SRAM_BASE_A(SB), .BMP_BASE_A(BB), .MAX_SECT0(MX0), .MAX_SECT1(MX1)) dut (
      .clk_sys(clk), .reset(reset), .img_mounted(img_mounted), .img_readonly(img_readonly),
      .img_size(img_size), .bk_load(bk_load), .bk_save(bk_save), .bk_ena(bk_ena),
      .bk_loading(bk_loading), .bk_saving(bk_saving), .sd_lba(sd_lba), .sd_rd(sd_rd),
      .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr), .sd_buff_dout(sd_buff_dout),
      .sd_buff_wr(sd_buff_wr), .sd_buff_din(sd_buff_din), .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_ack(mem_ack)
   );

   always #5 clk = ~clk;

   typedef struct {int v; int lba; bit wr;} req_t;
   req_t        log_q[$];
   logic [15:0] img[int];
   logic [15:0] mem[int];
   int m_n[2] = '{0, 0};
   bit m_ro[2] = '{0, 0};
   int errs = 0, checks = 0;
   int mem_delay = -1, nwr = 0, nrd = 0, mem_bad = 0, mem_ovl = 0, hs_bad = 0;
   int wr1_seen = 0, save_seen = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int key(input int v, input int l, input int w);
      return v * 1048576 + l * 256 + w;
   endfunction

   function automatic logic [63:0] rq(input int v, input int l, input bit wr);
      return {23'b0, v[7:0], l, wr};
   endfunction

   function automatic int waddr(input int v, input int l, input int w);
      logic [24:0] a;
      a = ((v != 0) ? BB : SB) + 25'(l * 512) + 25'(2 * w);
      return int'(a >> 1);
   endfunction

   // SD host: answers each one-hot request, streams a sector, checks request hold/drop.
   initial begin
      int v, l, d;
      bit wr;
      sd_ack = '0; sd_buff_addr = '0; sd_buff_dout = '0; sd_buff_wr = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset && (sd_rd != 0 || sd_wr != 0)) begin
            v  = (sd_rd[1] | sd_wr[1]) ? 1 : 0;
            wr = sd_wr != 0;
            l  = int'(sd_lba);
            d  = $urandom_range(0, 3);
            if ($countones({sd_rd, sd_wr}) != 1) hs_bad++;
            log_q.push_back('{v, l, wr});
            repeat (d) begin
               @(negedge clk);
               if (sd_lba != 32'(l) || (wr ? sd_wr[v] : sd_rd[v]) !== 1'b1) hs_bad++;
            end
            @(posedge clk); #1 sd_ack[v] = 1'b1;
            @(posedge clk); #1;
            if (sd_rd != 0 || sd_wr != 0) hs_bad++;
            for (int i = 0; i < 256; i++) begin
               sd_buff_addr = 8'(i);
               if (!wr) begin
                  sd_buff_dout = img[key(v, l, i)];
                  sd_buff_wr   = 1'b1;
               end
               @(posedge clk); #1;
               if (wr) img[key(v, l, i)] = sd_buff_din;
               if (sd_lba != 32'(l) && !reset) hs_bad++;
            end
            sd_buff_wr = 1'b0;
            sd_ack[v]  = 1'b0;
         end
      end
   end

   // SDRAM: one request at a time, ack after a configurable delay, request must hold steady.
   initial begin
      logic [24:0] a;
      logic [15:0] dn;
      logic        we;
      int          d;
      mem_ack = 1'b0; mem_dout = '0;
      forever begin
         @(negedge clk);
         if (mem_req) begin
            a = mem_addr; we = mem_we; dn = mem_din;
            d = (mem_delay < 0) ? $urandom_range(0, 3) : mem_delay;
            if (a[0]) mem_bad++;
            repeat (d) begin
               @(negedge clk);
               if (mem_req !== 1'b1 || mem_addr !== a || mem_we !== we || mem_din !== dn) mem_bad++;
            end
            @(posedge clk); #1 mem_ack = 1'b1;
            if (we) begin mem[int'(a >> 1)] = dn; nwr++; end
            else begin mem_dout = mem[int'(a >> 1)]; nrd++; end
            @(posedge clk); #1 mem_ack = 1'b0;
         end
      end
   end

   always @(negedge clk) begin
      if (sd_wr[1]) wr1_seen++;
      if (bk_saving) save_seen++;
      if (mem_req && sd_ack != 0) mem_ovl++;
   end

   task automatic mount(input int v, input longint sz, input bit r);
      longint n, mx;
      img_mounted[v] = 1'b1; img_size = 64'(sz); img_readonly = r;
      @(posedge clk); #1 img_mounted = '0;
      mx = (v != 0) ? MX1 : MX0;
      n  = sz / 512;
      m_n[v]  = int'((n > mx) ? mx : n);
      m_ro[v] = r;
   endtask

   task automatic fill_img(input int v, input int n, input bit ramp);
      for (int l = 0; l < n; l++)
         for (int w = 0; w < 256; w++) img[key(v, l, w)] = ramp ? 16'(l * 256 + w) : 16'($urandom);
   endtask

   task automatic run_op(input string tag, input bit ld, input bit sv, input bit poke);
      int sn[2];
      bit sro[2];
      bit sav;
      req_t exp_q[$];
      int cyc, bad, m0, nchk;
      sav = !ld && sv; sn = m_n; sro = m_ro; m0 = nwr + nrd; cyc = 0;
      log_q.delete();
      bk_load = ld; bk_save = sv;
      @(posedge clk); #1 bk_load = 1'b0; bk_save = 1'b0;
      while ((bk_loading || bk_saving) && cyc < 40000) begin
         @(posedge clk); #1 cyc++;
         if (poke && cyc == 300) begin bk_load = 1'b1; bk_save = 1'b1; end
         if (poke && cyc == 302) begin bk_load = 1'b0; bk_save = 1'b0; end
         if (poke && cyc == 400) mount(1, 512, 1'b0);
      end
      chk({tag, "_done"}, 64'(cyc < 40000), 1);
      for (int v = 0; v < 2; v++)
         if (sn[v] > 0 && !(sav && sro[v]))
            for (int l = 0; l < sn[v]; l++) exp_q.push_back('{v, l, sav});
      chk({tag, "_nreq"}, 64'(log_q.size()), 64'(exp_q.size()));
      nchk = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < nchk; i++)
         chk({tag, "_req"}, rq(log_q[i].v, log_q[i].lba, log_q[i].wr), rq(exp_q[i].v, exp_q[i].lba, exp_q[i].wr));
      bad = 0;
      foreach (exp_q[i])
         for (int w = 0; w < 256; w++)
            if (mem[waddr(exp_q[i].v, exp_q[i].lba, w)] !== img[key(exp_q[i].v, exp_q[i].lba, w)]) bad++;
      chk({tag, "_data"}, 64'(bad), 0);
      chk({tag, "_nmem"}, 64'(nwr + nrd - m0), 64'(256 * exp_q.size()));
   endtask

   initial begin
      int s0, w0, found;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctrl", {bk_ena, bk_loading, bk_saving, sd_rd, sd_wr, mem_req, mem_we, sd_lba}, 0);
      chk("rst_data", {mem_addr, mem_din, sd_buff_din}, 0);
      reset = 1'b0;
      @(posedge clk); #1;
      // 1: two-sector ramp load into vol0 image area
      fill_img(0, 2, 1'b1);
      mount(0, 1024, 1'b0);
      chk("t1_bk_ena", bk_ena, 1);
      run_op("t1", 1'b1, 1'b0, 1'b0);
      chk("t1_last_word", mem[waddr(0, 1, 255)], 16'h01FF);
      // 2: vol0 one sector then vol1 two sectors
      fill_img(0, 1, 1'b0);
      fill_img(1, 2, 1'b0);
      mount(0, 512, 1'b0);
      mount(1, 1024, 1'b0);
      run_op("t2", 1'b1, 1'b0, 1'b0);
      chk("t2_bmp200", mem[int'((BB + 25'h200) >> 1)], img[key(1, 1, 0)]);
      // 3: save with read-only vol1 skipped
      mount(0, 1024, 1'b0);
      mount(1, 1024, 1'b1);
      for (int k = 0; k < 512; k++) mem[waddr(0, 0, k)] = 16'hA500 ^ 16'(k);
      w0 = wr1_seen;
      run_op("t3", 1'b0, 1'b1, 1'b0);
      chk("t3_wr1", 64'(wr1_seen - w0), 0);
      chk("t3_word3", img[key(0, 1, 3)], 16'hA500 ^ 16'(259));
      // 4: load beats save on the same edge; busy edges and a mid-op mount change nothing
      fill_img(0, 2, 1'b0);
      fill_img(1, 2, 1'b0);
      mount(1, 1024, 1'b0);
      s0 = save_seen;
      run_op("t4", 1'b1, 1'b1, 1'b1);
      chk("t4_nosave", 64'(save_seen - s0), 0);
      // 5: slow SDRAM, vol0 too small to count, vol1 clamped to its cap
      mount(0, 100, 1'b0);
      chk("t5_bk_ena_off", bk_ena, 0);
      mount(1, 64'h100000, 1'b0);
      fill_img(1, MX1, 1'b0);
      mem_delay = 7;
      run_op("t5", 1'b1, 1'b0, 1'b0);
      mem_delay = -1;
      // random save of the clamped vol1
      for (int l = 0; l < MX1; l++)
         for (int w = 0; w < 256; w++) mem[waddr(1, l, w)] = 16'($urandom);
      run_op("t5s", 1'b0, 1'b1, 1'b0);
      // 6: reset while lba 3 is streaming
      mount(0, 8 * 512, 1'b0);
      fill_img(0, 8, 1'b0);
      log_q.delete();
      bk_load = 1'b1;
      @(posedge clk); #1 bk_load = 1'b0;
      found = 0;
      for (int c = 0; c < 20000 && found == 0; c++) begin
         @(posedge clk); #1;
         if (log_q.size() == 4 && sd_ack[0]) found = 1;
      end
      chk("t6_reach", 64'(found), 1);
      repeat (50) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("t6_rst_ctrl", {bk_ena, bk_loading, bk_saving, sd_rd, sd_wr, mem_req, mem_we, sd_lba}, 0);
      chk("t6_rst_data", {mem_addr, mem_din, sd_buff_din}, 0);
      repeat (300) @(posedge clk);
      #1 reset = 1'b0;
      m_n = '{0, 0}; m_ro = '{0, 0};
      @(posedge clk); #1;
      chk("t6_ena_clr", bk_ena, 0);
      fill_img(0, 2, 1'b0);
      mount(0, 1024, 1'b0);
      run_op("t6", 1'b1, 1'b0, 1'b0);
      chk("t6_first_lba", (log_q.size() > 0) ? 64'(log_q[0].lba) : 64'hFFFF, 0);
      chk("mem_proto", 64'(mem_bad + mem_ovl), 0);
      chk("sd_proto", 64'(hs_bad), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
